pdm_mic_frontend: RTL and testbench
===================================

Name: pdm_mic_frontend

Overview:
- PDM microphone front end upstream of the clap detector.
- Generates M_CLK, samples M_DATA and counts ones over a fixed window of PDM bits.
- Emits one unsigned PCM-like amplitude sample per window with a single-cycle valid strobe.
- Includes an enable/warm-up state machine so the downstream detector never sees microphone start-up garbage.

Parameters:
- CLK_DIV_HALF, 25, clk_i cycles per M_CLK half-period (100 MHz / 50 = 2 MHz M_CLK); legal range >= 2.
- WIN_BITS, 128, PDM bits per output sample; must be a power of two, range 16..1024.
- WARMUP_WIN, 2, number of complete windows discarded after entering warm-up; 0 is legal.
- OUT_W, $clog2(WIN_BITS)+1, width of sample_o; 8 with defaults.

Ports:
- clk_i  in  1  system clock, 100 MHz
- rst_i  in  1  reset; synchronous, active-high
- en_i  in  1  run enable; low stops the microphone clock
- M_DATA  in  1  PDM data from the microphone
- M_CLK  out  1  microphone clock, registered
- M_LRSEL  out  1  channel select, constant 0 (left channel)
- sample_o  out  OUT_W  ones count of the last full window (or magnitude, see Optional Feature)
- valid_o  out  1  one-cycle strobe; sample_o is new and stable until the next strobe
- running_o  out  1  high in RUN state

Behaviour:
- Reset values, in the cycle after rst_i is sampled high:
  - M_CLK=0, sample_o=0, valid_o=0, running_o=0.
  - All counters 0; state IDLE.
  - rst_i has priority over every other event.
- Divider:
  - A counter counts 0..CLK_DIV_HALF-1 while the state is not IDLE.
  - At terminal count, M_CLK toggles and the counter returns to 0.
  - In IDLE, the counter is held at 0 and M_CLK is held at 0.
- Bit sampling:
  - M_DATA passes through a 2-flop synchroniser.
  - The synchronised bit is sampled on the terminal-count cycle that takes M_CLK from 1 to 0 (end of the high phase).
  - Exactly one bit is taken per M_CLK period.
- Accumulation:
  - bit_cnt counts 0..WIN_BITS-1; ones_cnt adds the sampled bit.
  - ones_cnt range is 0..WIN_BITS (needs OUT_W bits, no overflow possible).
  - On the sample that makes bit_cnt wrap from WIN_BITS-1 to 0:
    - the final count includes that bit;
    - ones_cnt restarts at 0 on the next bit.
- States:
  - IDLE -> WARMUP when en_i=1.
  - WARMUP: windows run normally but produce no valid_o; a warm-up window counter increments per completed window. Go to RUN when WARMUP_WIN windows have completed (immediately if WARMUP_WIN=0).
  - RUN: each completed window loads sample_o and pulses valid_o. Latency is 1 cycle after the sampling cycle of the last bit.
  - Any state -> IDLE when en_i=0. The partial window is discarded, bit_cnt, ones_cnt and the warm-up counter clear, M_CLK drops to 0, and no valid_o is generated.
  - sample_o keeps its last value in IDLE.
- Simultaneous events:
  - en_i falls in the same cycle a window completes: the disable wins and there is no valid_o.
  - Re-enabling always restarts warm-up.
- running_o is registered and equals (state==RUN).

Optional Feature:
- Macro: PDM_MIC_FRONTEND_MAG_EN.
- Defined: sample_o = |ones_cnt - WIN_BITS/2|, range 0..WIN_BITS/2, zero-extended to OUT_W. The subtraction is computed in OUT_W+1 bits. This is one extra register stage, so latency becomes 2 cycles after the last bit; valid_o is delayed to match.
- Undefined: sample_o = raw ones_cnt, latency 1.

Decomposition:
- Shared package pdm_pkg:
  - state enum (IDLE, WARMUP, RUN);
  - localparam defaults for CLK_DIV_HALF and WIN_BITS;
  - a function computing OUT_W from WIN_BITS.
- One natural sub-module: pdm_clk_gen. It holds the divider, the M_CLK register and a sample_tick_o strobe, with a hold input driven by IDLE.
- Window accumulation and the state machine stay in the top.

Test Plan:
- Reset, then en_i=1 with M_DATA=1 constantly, defaults:
  - M_CLK period is 50 cycles.
  - First valid_o arrives after 3 windows (2 warm-up windows + 1).
  - sample_o=128 (MAG_EN defined: 64).
- M_DATA=0 constantly -> every valid_o carries sample_o=0 (MAG_EN: 64).
- M_DATA alternating 1/0 on successive M_CLK periods -> sample_o=64 (MAG_EN: 0). valid_o spacing is exactly 128*50=6400 cycles.
- en_i dropped at bit 70 of a RUN window, re-raised 100 cycles later:
  - M_CLK goes to 0 and no valid_o is produced for the partial window;
  - the next valid_o comes only after 2 new warm-up windows, and its count starts from zero.
- rst_i pulsed for 1 cycle mid-window in RUN:
  - all outputs return to reset values in the next cycle;
  - the state is IDLE even though en_i=1, then the block moves to WARMUP on the following cycle.
- WARMUP_WIN=0, CLK_DIV_HALF=2, WIN_BITS=16, M_DATA=1 -> first valid_o 1 cycle after the 16th sample tick, with sample_o=16.

Source files
------------

// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared state type, default parameters and width helper for the PDM front end
package pdm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } pdm_state_t;

   localparam int DEF_CLK_DIV_HALF = 25;
   localparam int DEF_WIN_BITS     = 128;
   localparam int DEF_WARMUP_WIN   = 2;

   // A full window of ones is WIN_BITS itself, hence the extra bit.
   function automatic int out_w(input int win_bits);
      return $clog2(win_bits) + 1;
   endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - microphone clock divider with a strobe at the end of each M_CLK high phase
module pdm_clk_gen
   import pdm_pkg::*;
#(
   parameter int CLK_DIV_HALF = DEF_CLK_DIV_HALF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_hold,
   output logic o_m_clk,
   output logic o_sample_tick
);

   localparam int DIV_W = $clog2(CLK_DIV_HALF);

   logic [DIV_W-1:0] r_div_cnt;
   logic             r_m_clk;
   logic             w_tc;

   assign w_tc = (r_div_cnt == DIV_W'(CLK_DIV_HALF - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || i_hold) begin
         r_div_cnt <= '0;
         r_m_clk   <= 1'b0;
      end else if (w_tc) begin
         r_div_cnt <= '0;
         r_m_clk   <= ~r_m_clk;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   // Data is taken on the terminal count that ends the high phase.
   assign o_sample_tick = w_tc & r_m_clk & ~i_hold;
   assign o_m_clk       = r_m_clk;

endmodule

// File: rtl/pdm_mic_frontend.sv
// rtl/pdm_mic_frontend.sv - PDM mic front end: ones count per window, warm-up FSM; PDM_MIC_FRONTEND_MAG_EN selects |count - WIN_BITS/2| output
module pdm_mic_frontend
   import pdm_pkg::*;
#(
   parameter int CLK_DIV_HALF = DEF_CLK_DIV_HALF,
   parameter int WIN_BITS     = DEF_WIN_BITS,
   parameter int WARMUP_WIN   = DEF_WARMUP_WIN,
   parameter int OUT_W        = out_w(WIN_BITS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             M_DATA,
   output logic             M_CLK,
   output logic             M_LRSEL,
   output logic [OUT_W-1:0] sample_o,
   output logic             valid_o,
   output logic             running_o
);

   localparam int BIT_W  = $clog2(WIN_BITS);
   localparam int WARM_W = (WARMUP_WIN > 0) ? $clog2(WARMUP_WIN + 1) : 1;
   localparam logic [WARM_W-1:0] WARM_TGT = WARM_W'(WARMUP_WIN);

   pdm_state_t       r_state;
   logic             r_running;
   logic [1:0]       r_sync;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [OUT_W-1:0] r_ones_cnt;
   logic [WARM_W-1:0] r_warm_cnt;
   logic [OUT_W-1:0] r_win_cnt;
   logic             r_win_vld;

   logic             w_hold;
   logic             w_tick;
   logic             w_win_done;
   logic [OUT_W-1:0] w_ones_next;

   // Holding on a low en_i too makes M_CLK drop in the same cycle the FSM returns to IDLE.
   assign w_hold = (r_state == ST_IDLE) || !en_i;

   pdm_clk_gen #(
      .CLK_DIV_HALF (CLK_DIV_HALF)
   ) u_clk_gen (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .i_hold        (w_hold),
      .o_m_clk       (M_CLK),
      .o_sample_tick (w_tick)
   );

   assign M_LRSEL     = 1'b0;
   assign w_ones_next = r_ones_cnt + OUT_W'(r_sync[1]);
   assign w_win_done  = w_tick && (r_bit_cnt == BIT_W'(WIN_BITS - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], M_DATA};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_running  <= 1'b0;
         r_bit_cnt  <= '0;
         r_ones_cnt <= '0;
         r_warm_cnt <= '0;
         r_win_cnt  <= '0;
         r_win_vld  <= 1'b0;
      end else begin
         r_win_vld <= 1'b0;
         if (!en_i) begin
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
            r_warm_cnt <= '0;
         end else begin
            if (w_tick) begin
               if (w_win_done) begin
                  r_bit_cnt  <= '0;
                  r_ones_cnt <= '0;
               end else begin
                  r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                  r_ones_cnt <= w_ones_next;
               end
            end
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_WARMUP;
               end
               ST_WARMUP: begin
                  if (r_warm_cnt == WARM_TGT) begin
                     r_state   <= ST_RUN;
                     r_running <= 1'b1;
                  end else if (w_win_done) begin
                     r_warm_cnt <= r_warm_cnt + WARM_W'(1);
                  end
               end
               ST_RUN: begin
                  if (w_win_done) begin
                     r_win_cnt <= w_ones_next;
                     r_win_vld <= 1'b1;
                  end
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PDM_MIC_FRONTEND_MAG_EN
   logic [OUT_W:0]   w_diff;
   logic [OUT_W:0]   w_mag;
   logic [OUT_W-1:0] r_sample;
   logic             r_valid;

   assign w_diff = {1'b0, r_win_cnt} - (OUT_W + 1)'(WIN_BITS / 2);
   assign w_mag  = w_diff[OUT_W] ? -w_diff : w_diff;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sample <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= r_win_vld;
         if (r_win_vld) begin
            r_sample <= OUT_W'(w_mag);
         end
      end
   end

   assign sample_o = r_sample;
   assign valid_o  = r_valid;
`else
   assign sample_o = r_win_cnt;
   assign valid_o  = r_win_vld;
`endif

   assign running_o = r_running;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// tb/tb_pdm_mic_frontend.sv - scoreboard bench for pdm_mic_frontend, default and small-window instances
module tb_pdm_mic_frontend;
   import pdm_pkg::*;

   localparam int HALF    = DEF_CLK_DIV_HALF;
   localparam int WIN     = DEF_WIN_BITS;
   localparam int WARM    = 2;
   localparam int OUT_W   = out_w(WIN);
   localparam int S_WIN   = 16;
   localparam int S_OUT_W = out_w(S_WIN);
`ifdef PDM_MIC_FRONTEND_MAG_EN
   localparam int LAT       = 1;
   localparam int EXP_ONES  = 64;
   localparam int EXP_ZEROS = 64;
   localparam int EXP_ALT   = 0;
   localparam int EXP_SMALL = 8;
`else
   localparam int LAT       = 0;
   localparam int EXP_ONES  = 128;
   localparam int EXP_ZEROS = 0;
   localparam int EXP_ALT   = 64;
   localparam int EXP_SMALL = 16;
`endif
   localparam int WIN_CYC     = 2 * HALF * WIN;
   localparam int FIRST_VALID = 1 + WIN_CYC * (WARM + 1) + LAT;
   localparam int SMALL_FIRST = 1 + 2 * 2 * S_WIN + LAT;

   logic               clk;
   logic               rst;
   logic               en;
   logic               m_data;
   logic               m_clk;
   logic               m_lrsel;
   logic [OUT_W-1:0]   sample_o;
   logic               valid_o;
   logic               running_o;

   logic               s_en;
   logic               s_data;
   logic               s_m_clk;
   logic               s_lrsel;
   logic [S_OUT_W-1:0] s_sample;
   logic               s_valid;
   logic               s_running;

   int                 checks;
   int                 failures;
   logic [OUT_W-1:0]   exp_q[$];

   pdm_mic_frontend u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .M_DATA    (m_data),
      .M_CLK     (m_clk),
      .M_LRSEL   (m_lrsel),
      .sample_o  (sample_o),
      .valid_o   (valid_o),
      .running_o (running_o)
   );

   pdm_mic_frontend #(
      .CLK_DIV_HALF (2),
      .WIN_BITS     (S_WIN),
      .WARMUP_WIN   (0)
   ) u_small (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (s_en),
      .M_DATA    (s_data),
      .M_CLK     (s_m_clk),
      .M_LRSEL   (s_lrsel),
      .sample_o  (s_sample),
      .valid_o   (s_valid),
      .running_o (s_running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits for valid_o, then pops the scoreboard and compares the sample.
   task automatic wait_valid(input int budget, input bit toggle, output int waited,
                             output int rise1, output int rise2);
      logic prev;
      logic [OUT_W-1:0] want;
      prev   = m_clk;
      waited = 0;
      rise1  = -1;
      rise2  = -1;
      while (waited < budget) begin
         @(negedge clk);
         waited++;
         if (m_clk && !prev) begin
            if (rise1 < 0) rise1 = waited;
            else if (rise2 < 0) rise2 = waited;
            if (toggle) m_data = ~m_data;
         end
         prev = m_clk;
         if (valid_o) break;
      end
      if (valid_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_valid sample_o=%0d expected=none", sample_o);
         end else begin
            want = exp_q.pop_front();
            if (sample_o !== want) begin
               failures++;
               $display("FAIL sb_sample got=%0d want=%0d", sample_o, want);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (m_clk !== 1'b0) begin failures++; $display("FAIL reset_m_clk got=%b want=0", m_clk); end
      checks++; if (m_lrsel !== 1'b0) begin failures++; $display("FAIL reset_lrsel got=%b want=0", m_lrsel); end
      checks++; if (sample_o !== '0) begin failures++; $display("FAIL reset_sample got=%0d want=0", sample_o); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
      checks++; if (running_o !== 1'b0) begin failures++; $display("FAIL reset_running got=%b want=0", running_o); end
      checks++; if (s_m_clk !== 1'b0) begin failures++; $display("FAIL reset_small_m_clk got=%b want=0", s_m_clk); end
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_small_valid got=%b want=0", s_valid); end
      rst = 1'b0;
   endtask

   task automatic test_small_no_warmup();
      int n;
      int falls;
      logic prev;
      @(negedge clk);
      s_en  = 1'b1;
      n     = 0;
      falls = 0;
      prev  = s_m_clk;
      while (n < SMALL_FIRST + 20) begin
         @(negedge clk);
         n++;
         if (prev && !s_m_clk) falls++;
         prev = s_m_clk;
         if (s_valid) break;
      end
      checks++; if (n != SMALL_FIRST) begin failures++; $display("FAIL small_latency got=%0d want=%0d", n, SMALL_FIRST); end
      checks++; if (falls != S_WIN) begin failures++; $display("FAIL small_ticks got=%0d want=%0d", falls, S_WIN); end
      checks++; if (s_sample !== S_OUT_W'(EXP_SMALL)) begin failures++; $display("FAIL small_sample got=%0d want=%0d", s_sample, EXP_SMALL); end
      checks++; if (s_running !== 1'b1) begin failures++; $display("FAIL small_running got=%b want=1", s_running); end
      @(negedge clk);
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL small_valid_width got=%b want=0", s_valid); end
      s_en = 1'b0;
   endtask

   task automatic test_const_one();
      int n, r1, r2;
      @(negedge clk);
      m_data = 1'b1;
      en     = 1'b1;
      exp_q.push_back(OUT_W'(EXP_ONES));
      wait_valid(FIRST_VALID + 100, 1'b0, n, r1, r2);
      checks++; if (r1 != HALF + 1) begin failures++; $display("FAIL mclk_first_rise got=%0d want=%0d", r1, HALF + 1); end
      checks++; if (r2 - r1 != 2 * HALF) begin failures++; $display("FAIL mclk_period got=%0d want=%0d", r2 - r1, 2 * HALF); end
      checks++; if (n != FIRST_VALID) begin failures++; $display("FAIL first_valid_latency got=%0d want=%0d", n, FIRST_VALID); end
      checks++; if (running_o !== 1'b1) begin failures++; $display("FAIL run_running got=%b want=1", running_o); end
      @(negedge clk);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL valid_width got=%b want=0", valid_o); end
   endtask

   task automatic test_const_zero();
      int n, r1, r2;
      m_data = 1'b0;
      exp_q.push_back(OUT_W'(EXP_ZEROS));
      wait_valid(WIN_CYC + 100, 1'b0, n, r1, r2);
      checks++; if (n != WIN_CYC - 1) begin failures++; $display("FAIL zero_spacing got=%0d want=%0d", n, WIN_CYC - 1); end
   endtask

   task automatic test_alternating();
      int n, r1, r2;
      exp_q.push_back(OUT_W'(EXP_ALT));
      exp_q.push_back(OUT_W'(EXP_ALT));
      for (int w = 0; w < 2; w++) begin
         wait_valid(WIN_CYC + 100, 1'b1, n, r1, r2);
         checks++; if (n != WIN_CYC) begin failures++; $display("FAIL alt_spacing%0d got=%0d want=%0d", w, n, WIN_CYC); end
      end
   endtask

   task automatic test_disable_reenable();
      int n, r1, r2, falls, idle_valids, idle_clk;
      logic prev;
      m_data = 1'b1;
      falls  = 0;
      n      = 0;
      prev   = m_clk;
      while (falls < 70 && n < 80 * 2 * HALF) begin
         @(negedge clk);
         n++;
         if (prev && !m_clk) falls++;
         prev = m_clk;
      end
      checks++; if (falls != 70) begin failures++; $display("FAIL dis_bit70 got=%0d want=70", falls); end
      en = 1'b0;
      @(negedge clk);
      checks++; if (m_clk !== 1'b0) begin failures++; $display("FAIL dis_m_clk got=%b want=0", m_clk); end
      checks++; if (running_o !== 1'b0) begin failures++; $display("FAIL dis_running got=%b want=0", running_o); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL dis_valid got=%b want=0", valid_o); end
      idle_valids = 0;
      idle_clk    = 0;
      repeat (100) begin
         @(negedge clk);
         if (valid_o) idle_valids++;
         if (m_clk) idle_clk++;
      end
      checks++; if (idle_valids != 0) begin failures++; $display("FAIL dis_idle_valids got=%0d want=0", idle_valids); end
      checks++; if (idle_clk != 0) begin failures++; $display("FAIL dis_idle_m_clk got=%0d want=0", idle_clk); end
      en = 1'b1;
      exp_q.push_back(OUT_W'(EXP_ONES));
      wait_valid(FIRST_VALID + 100, 1'b0, n, r1, r2);
      checks++; if (n != FIRST_VALID) begin failures++; $display("FAIL reen_latency got=%0d want=%0d", n, FIRST_VALID); end
   endtask

   task automatic test_reset_mid_run();
      int n, ran;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (m_clk !== 1'b0) begin failures++; $display("FAIL rmid_m_clk got=%b want=0", m_clk); end
      checks++; if (sample_o !== '0) begin failures++; $display("FAIL rmid_sample got=%0d want=0", sample_o); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b want=0", valid_o); end
      checks++; if (running_o !== 1'b0) begin failures++; $display("FAIL rmid_running got=%b want=0", running_o); end
      rst = 1'b0;
      n   = 0;
      ran = 0;
      while (!m_clk && n < 4 * HALF) begin
         @(negedge clk);
         n++;
         if (running_o) ran++;
      end
      checks++; if (n != HALF + 1) begin failures++; $display("FAIL rmid_restart got=%0d want=%0d", n, HALF + 1); end
      checks++; if (ran != 0) begin failures++; $display("FAIL rmid_warmup_running got=%0d want=0", ran); end
      en = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      en       = 1'b0;
      m_data   = 1'b0;
      s_en     = 1'b0;
      s_data   = 1'b1;
      test_reset();
      test_small_no_warmup();
      test_const_one();
      test_const_zero();
      test_alternating();
      test_disable_reenable();
      test_reset_mid_run();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
